gbuff_port_arbiter: RTL and testbench
=====================================

# gbuff_port_arbiter

Controller that shares one single-port accumulating global buffer (`global_buffer_bram_acc`-style: registered read, write/accumulate, 1-cycle read latency) between two requesters: port 0 (host/DMA loader) and port 1 (PE-array partial-sum writeback/readout). It arbitrates round-robin with burst locking, returns tagged read responses, and runs a zero-fill sweep of the whole buffer before each accumulation pass. It sits between the requesters and the BRAM's `ram_en/wr_en/acc_mode/index/data_in/data_out` pins.

## Interface
- `ADDR_BITS`, 8, buffer address width; DEPTH = 2**ADDR_BITS
- `DATA_BITS`, 128, word width
- `clk`  in  1  single clock
- `rst`  in  1  reset, asynchronous, active-high
- `req{0,1}_valid`  in  1  request present
- `req{0,1}_ready`  out  1  request accepted this cycle when valid&ready
- `req{0,1}_wr`  in  1  1 = write, 0 = read
- `req{0,1}_acc`  in  1  write adds lane-wise (4×32-bit signed) instead of overwriting
- `req{0,1}_last`  in  1  final beat of burst; releases the grant
- `req{0,1}_addr`  in  ADDR_BITS  word address
- `req{0,1}_wdata`  in  DATA_BITS  write data
- `rsp_valid`  out  1  one-cycle pulse, read data valid; no backpressure
- `rsp_id`  out  1  requester that issued the read
- `rsp_data`  out  DATA_BITS  read data (= `ram_data_out`)
- `clr_start`  in  1  request a zero-fill sweep
- `clr_busy`  out  1  sweep in progress
- `clr_done`  out  1  one-cycle pulse after final zero write
- `ram_en`, `ram_wr_en`, `ram_acc_mode`  out  1  BRAM controls
- `ram_index`  out  ADDR_BITS;  `ram_data_in`  out  DATA_BITS;  `ram_data_out`  in  DATA_BITS

## Operation
- States: IDLE, BURST0, BURST1, CLEAR. Reset: IDLE, rr pointer = 0; all outputs 0.
- IDLE: `clr_start` wins over requests → CLEAR (no request accepted that cycle). Else one valid: ready to it. Both valid: ready to pointer side.
- Accepted beat with `last`=0 → BURSTn (only port n ready until a `last` beat is accepted). Accepted beat with `last`=1 → IDLE.
- Pointer toggles to the other port whenever a `last` beat is accepted, regardless of contention.
- BURSTn with `req_n_valid`=0: hold state, issue nothing; other port stays blocked.
- `clr_start` outside IDLE: ignored (not queued).
- CLEAR: counter 0..DEPTH-1, one write/cycle, `ram_wr_en`=1, `ram_acc_mode`=0, data 0; both readies 0; `clr_busy`=1. After index DEPTH-1 → IDLE, `clr_done` pulses next cycle. Counter resets to 0 on entry.
- BRAM drive is combinational from the accepted beat: `ram_en` = accept | CLEAR; `ram_wr_en`=wr; `ram_acc_mode`=wr&acc; index/data from the granted port. No accept → `ram_en`=0.
- Read accept at cycle t → `rsp_valid`=1, `rsp_id`=port at t+1; `rsp_data` tracks `ram_data_out`.
- Accumulation width: lane-wise 32-bit signed wrap, performed in BRAM; controller does not check overflow.

## Timing
- Zero-bubble: back-to-back beats from one port or alternating ports, one per cycle.
- Read latency exactly 1 cycle; write-then-read same address on consecutive cycles returns updated value.
- Sweep: DEPTH cycles busy + `clr_done` at cycle DEPTH+1 after `clr_start`.
- `rst` mid-burst or mid-sweep: immediate IDLE, pointer 0, `rsp_valid`/`clr_*` 0; BRAM contents undefined for in-flight sweep.

## Structure
- Package `gbuff_ctrl_pkg`: state enum (IDLE/BURST0/BURST1/CLEAR), port-id constants, lane width 32.
- Sub-module `rr_arb2`: 2-way round-robin grant with pointer register and lock input; FSM, clear counter, and response register stay in top.

## Test plan
- Reset, port 0 writes 0x11 to addr 5, reads addr 5 → `rsp_valid` 1 cycle later, `rsp_id`=0, data 0x11.
- Both ports valid, 1-beat bursts ×4 → grants 0,1,0,1; pointer ends at 0.
- Port 1 3-beat burst (last on beat 3) while port 0 valid throughout → port 0 ready only after beat 3.
- Write lanes {1,−2,3,0x7FFFFFFF} then acc {1,1,1,1} → read {2,−1,4,0x80000000}.
- `clr_start` with DEPTH=16 after filling nonzero data → readies 0 for 16 cycles, `clr_done` at cycle 17, all reads return 0.
- Assert `rst` during BURST1 beat 2 → readies/`rsp_valid` 0, next request served from IDLE with pointer 0.

Source files
------------

// File: rtl/gbuff_ctrl_pkg.sv
// gbuff_ctrl_pkg: shared types and constants for the global-buffer port arbiter
package gbuff_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, BURST0, BURST1, CLEAR} state_t;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
    localparam int LANE_BITS = 32;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin grant with burst lock and toggling pointer
// Ports: req (valids), lock/lock_id (burst owner), block (grant nobody),
//        last (last flag of the granted beat), gnt (one-hot accept), gnt_id (selected port)
module rr_arb2
    import gbuff_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       lock,
    input  logic       lock_id,
    input  logic       block,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gnt_id
);
    logic ptr_q, ptr_d;

    always_comb begin
        gnt_id = lock ? lock_id : (&req ? ptr_q : req[1]);
        gnt = block ? 2'b00 : req & (gnt_id == PORT1 ? 2'b10 : 2'b01);
        // pointer flips on every accepted last beat, contended or not
        ptr_d = ptr_q ^ (|gnt & last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= PORT0;
        else ptr_q <= ptr_d;
    end
endmodule

// File: rtl/gbuff_port_arbiter.sv
// gbuff_port_arbiter: shares one accumulating single-port buffer between two requesters
// Ports: req0_*/req1_* (valid/ready beats with wr/acc/last/addr/wdata),
//        rsp_* (tagged read data, 1-cycle latency), clr_* (zero-fill sweep control),
//        ram_* (combinational BRAM drive, ram_data_out is the registered read data)
module gbuff_port_arbiter
    import gbuff_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_wr,
    input  logic                 req0_acc,
    input  logic                 req0_last,
    input  logic [ADDR_BITS-1:0] req0_addr,
    input  logic [DATA_BITS-1:0] req0_wdata,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_wr,
    input  logic                 req1_acc,
    input  logic                 req1_last,
    input  logic [ADDR_BITS-1:0] req1_addr,
    input  logic [DATA_BITS-1:0] req1_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [DATA_BITS-1:0] rsp_data,
    input  logic                 clr_start,
    output logic                 clr_busy,
    output logic                 clr_done,
    output logic                 ram_en,
    output logic                 ram_wr_en,
    output logic                 ram_acc_mode,
    output logic [ADDR_BITS-1:0] ram_index,
    output logic [DATA_BITS-1:0] ram_data_in,
    input  logic [DATA_BITS-1:0] ram_data_out
);
    localparam logic [ADDR_BITS-1:0] LAST_IDX = '1;

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_id_q, rsp_id_d;
    logic                  clr_done_q, clr_done_d;
    logic [1:0]            gnt;
    logic                  sel, accept, clearing, block;
    logic                  sel_wr, sel_acc, sel_last;
    logic [ADDR_BITS-1:0]  sel_addr;
    logic [DATA_BITS-1:0]  sel_wdata;

    always_comb begin
        clearing = state_q == CLEAR;
        // reset and a pending/ongoing sweep both keep every ready low
        block = rst | clearing | (state_q == IDLE && clr_start);
        accept = |gnt;
        sel_wr = sel ? req1_wr : req0_wr;
        sel_acc = sel ? req1_acc : req0_acc;
        sel_last = sel ? req1_last : req0_last;
        sel_addr = sel ? req1_addr : req0_addr;
        sel_wdata = sel ? req1_wdata : req0_wdata;
    end

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1_valid, req0_valid}),
        .lock    (state_q == BURST0 || state_q == BURST1),
        .lock_id (state_q == BURST1),
        .block   (block),
        .last    (sel_last),
        .gnt     (gnt),
        .gnt_id  (sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= PORT0;
            clr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            clr_done_q  <= clr_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = clr_start ? CLEAR : (accept && !sel_last) ? (sel == PORT1 ? BURST1 : BURST0) : IDLE;
            BURST0,
            BURST1:  state_d = (accept && sel_last) ? IDLE : state_q;
            default: state_d = cnt_q == LAST_IDX ? IDLE : CLEAR;
        endcase
        // counter idles at zero, so the sweep always starts from index 0
        cnt_d = clearing ? cnt_q + 1'b1 : '0;
        rsp_valid_d = accept & ~sel_wr;
        rsp_id_d = sel;
        clr_done_d = clearing && cnt_q == LAST_IDX;
    end

    always_comb begin
        req0_ready = gnt[0];
        req1_ready = gnt[1];
        rsp_valid = rsp_valid_q;
        rsp_id = rsp_id_q;
        rsp_data = ram_data_out;
        clr_busy = clearing;
        clr_done = clr_done_q;
        ram_en = accept | clearing;
        ram_wr_en = clearing | (accept & sel_wr);
        ram_acc_mode = accept & sel_wr & sel_acc;
        ram_index = clearing ? cnt_q : sel_addr;
        ram_data_in = clearing ? '0 : sel_wdata;
    end
endmodule

// File: tb/tb_gbuff_port_arbiter.sv
// tb_gbuff_port_arbiter: directed checks of arbitration, bursts, accumulation, sweep and reset
module tb_gbuff_port_arbiter;
    localparam int AB = 4;
    localparam int DB = 128;

    logic          clk, rst;
    logic          req0_valid, req0_ready, req0_wr, req0_acc, req0_last;
    logic [AB-1:0] req0_addr;
    logic [DB-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_wr, req1_acc, req1_last;
    logic [AB-1:0] req1_addr;
    logic [DB-1:0] req1_wdata;
    logic          rsp_valid, rsp_id;
    logic [DB-1:0] rsp_data;
    logic          clr_start, clr_busy, clr_done;
    logic          ram_en, ram_wr_en, ram_acc_mode;
    logic [AB-1:0] ram_index;
    logic [DB-1:0] ram_data_in, ram_data_out;
    logic [DB-1:0] mem [16];
    int            checks, errors;

    gbuff_port_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr), .req0_acc(req0_acc),
        .req0_last(req0_last), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr), .req1_acc(req1_acc),
        .req1_last(req1_last), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_en(ram_en), .ram_wr_en(ram_wr_en), .ram_acc_mode(ram_acc_mode),
        .ram_index(ram_index), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // accumulating BRAM with registered read
    initial for (int i = 0; i < 16; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr_en) begin
                if (ram_acc_mode)
                    for (int l = 0; l < 4; l++) mem[ram_index][l*32 +: 32] <= mem[ram_index][l*32 +: 32] + ram_data_in[l*32 +: 32];
                else
                    mem[ram_index] <= ram_data_in;
            end else ram_data_out <= mem[ram_index];
        end
    end

    task automatic chk(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int p, input logic v, input logic wr, input logic acc, input logic last,
                       input logic [AB-1:0] a, input logic [DB-1:0] d);
        if (p == 0) begin
            req0_valid = v; req0_wr = wr; req0_acc = acc; req0_last = last; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_wr = wr; req1_acc = acc; req1_last = last; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 0; rst = 1; clr_start = 0; checks = 0; errors = 0; ram_data_out = '0;
        drv(0, 1, 0, 0, 1, 4'd5, '0);
        drv(1, 0, 0, 0, 0, 4'd0, '0);
        tick; tick;
        chk("reset_ready0", req0_ready, 0);
        chk("reset_ready1", req1_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_clr_busy", clr_busy, 0);
        chk("reset_clr_done", clr_done, 0);
        chk("reset_ram_en", ram_en, 0);
        drv(0, 0, 0, 0, 0, 4'd0, '0);
        rst = 0;
        tick;
        // write then read addr 5 from port 0
        drv(0, 1, 1, 0, 1, 4'd5, 128'h11); #1;
        chk("wr_ready0", req0_ready, 1);
        chk("wr_ram_en", ram_en, 1);
        chk("wr_ram_wr_en", ram_wr_en, 1);
        chk("wr_index", ram_index, 5);
        chk("wr_data", ram_data_in, 128'h11);
        tick;
        drv(0, 1, 0, 0, 1, 4'd5, '0); #1;
        chk("rd_ready0", req0_ready, 1);
        chk("rd_ram_wr_en", ram_wr_en, 0);
        tick;
        drv(0, 0, 0, 0, 0, 4'd0, '0); #1;
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_id", rsp_id, 0);
        chk("rd_rsp_data", rsp_data, 128'h11);
        chk("idle_ram_en", ram_en, 0);
        tick;
        chk("rsp_pulse", rsp_valid, 0);
        // contention, single-beat bursts alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            drv(0, 1, 1, 0, 1, 4'd1, 128'hA0 + i);
            drv(1, 1, 1, 0, 1, 4'd2, 128'hB0 + i); #1;
            chk("rr_ready0", req0_ready, (i % 2) == 0);
            chk("rr_ready1", req1_ready, (i % 2) == 1);
            chk("rr_index", ram_index, (i % 2) ? 2 : 1);
            tick;
        end
        // pointer back at 0: port 0 wins, then port 1 takes a 3-beat burst
        drv(0, 1, 1, 0, 1, 4'd3, 128'hC3);
        drv(1, 1, 1, 0, 0, 4'd8, 128'hD8); #1;
        chk("ptr0_ready0", req0_ready, 1);
        chk("ptr0_ready1", req1_ready, 0);
        tick;
        chk("b1_ready1", req1_ready, 1);
        chk("b1_ready0", req0_ready, 0);
        chk("b1_index", ram_index, 8);
        tick;
        drv(1, 0, 1, 0, 0, 4'd9, 128'hD9); #1;
        chk("gap_ready0", req0_ready, 0);
        chk("gap_ready1", req1_ready, 0);
        chk("gap_ram_en", ram_en, 0);
        tick;
        drv(1, 1, 1, 0, 0, 4'd9, 128'hD9); #1;
        chk("b2_ready1", req1_ready, 1);
        chk("b2_ready0", req0_ready, 0);
        tick;
        drv(1, 1, 1, 0, 1, 4'd10, 128'hDA); #1;
        chk("b3_ready1", req1_ready, 1);
        chk("b3_ready0", req0_ready, 0);
        tick;
        drv(1, 0, 0, 0, 0, 4'd0, '0); #1;
        chk("post_ready0", req0_ready, 1);
        chk("post_index", ram_index, 3);
        tick;
        // lane-wise signed accumulation with wrap
        drv(0, 1, 1, 0, 1, 4'd7, {32'h7FFFFFFF, 32'd3, 32'hFFFFFFFE, 32'd1}); #1;
        chk("acc_wr_mode", ram_acc_mode, 0);
        tick;
        drv(0, 1, 1, 1, 1, 4'd7, {32'd1, 32'd1, 32'd1, 32'd1}); #1;
        chk("acc_mode", ram_acc_mode, 1);
        chk("acc_wr_en", ram_wr_en, 1);
        tick;
        drv(0, 1, 0, 0, 1, 4'd7, '0); #1;
        chk("acc_rd_mode", ram_acc_mode, 0);
        tick;
        drv(0, 0, 0, 0, 0, 4'd0, '0); #1;
        chk("acc_rsp_valid", rsp_valid, 1);
        chk("acc_rsp_data", rsp_data, {32'h80000000, 32'd4, 32'hFFFFFFFF, 32'd2});
        tick;
        // zero-fill sweep, port 0 waits with a read of addr 5
        drv(0, 1, 0, 0, 1, 4'd5, '0);
        clr_start = 1; #1;
        chk("clr_start_ready0", req0_ready, 0);
        chk("clr_start_ram_en", ram_en, 0);
        chk("clr_start_busy", clr_busy, 0);
        tick;
        for (int i = 0; i < 16; i++) begin
            clr_start = (i == 5); #1;
            chk("clr_busy", clr_busy, 1);
            chk("clr_ready0", req0_ready, 0);
            chk("clr_ram_en", ram_en, 1);
            chk("clr_wr_en", ram_wr_en, 1);
            chk("clr_acc", ram_acc_mode, 0);
            chk("clr_index", ram_index, i);
            chk("clr_data", ram_data_in, 0);
            chk("clr_done_early", clr_done, 0);
            tick;
        end
        clr_start = 0; #1;
        chk("clr_end_busy", clr_busy, 0);
        chk("clr_done", clr_done, 1);
        chk("clr_end_ready0", req0_ready, 1);
        tick;
        drv(0, 1, 0, 0, 1, 4'd7, '0); #1;
        chk("clr_done_pulse", clr_done, 0);
        chk("clr_rd5_valid", rsp_valid, 1);
        chk("clr_rd5_data", rsp_data, 0);
        tick;
        drv(0, 1, 0, 0, 1, 4'd9, '0); #1;
        chk("clr_rd7_data", rsp_data, 0);
        tick;
        drv(0, 0, 0, 0, 0, 4'd0, '0); #1;
        chk("clr_rd9_data", rsp_data, 0);
        tick;
        // reset in the middle of a port 1 read burst
        drv(1, 1, 0, 0, 0, 4'd2, '0); #1;
        chk("rb1_ready1", req1_ready, 1);
        tick;
        drv(1, 1, 0, 0, 0, 4'd3, '0); #1;
        chk("rb2_rsp_valid", rsp_valid, 1);
        chk("rb2_rsp_id", rsp_id, 1);
        chk("rb2_ready1", req1_ready, 1);
        rst = 1; #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ram_en", ram_en, 0);
        tick;
        rst = 0;
        drv(0, 1, 1, 0, 1, 4'd4, 128'h44);
        drv(1, 1, 1, 0, 1, 4'd6, 128'h66); #1;
        chk("after_rst_ready0", req0_ready, 1);
        chk("after_rst_ready1", req1_ready, 0);
        tick;
        drv(0, 0, 0, 0, 0, 4'd0, '0);
        drv(1, 0, 0, 0, 0, 4'd0, '0); #1;
        chk("after_rst_rsp_valid", rsp_valid, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
